// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time, buffers {inst, pc, fault} for decode.
// Latency: request accepted at t, response at t+1 -> out_valid at t+2; next request the cycle after the handshake.
// Backpressure: out_ready low holds the buffered word stable and stalls fetching; imem_req_ready low holds the request.
module ysyx_23060096_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_DROP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        aligned;
    logic        req_fire;

    // A misaligned PC never reaches memory; it is turned into a faulting NOP instead.
    assign aligned        = (pc[1:0] == 2'b00);
    assign imem_req_valid = !rst && (state == S_REQ) && aligned;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // The buffer is only presented while in HOLD; state is a register so this is glitch-free.
    assign out_valid      = (state == S_HOLD);

    // Fetch sequencer: redirect outranks every other PC update, a stale response is dropped via DROP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            out_inst  <= 32'd0;
            out_pc    <= RESET_PC;
            out_fault <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            case (state)
                S_REQ:   state <= req_fire ? S_DROP : S_REQ;
                S_WAIT:  state <= imem_resp_valid ? S_REQ : S_DROP;
                S_DROP:  state <= imem_resp_valid ? S_REQ : S_DROP;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (!aligned) begin
                        out_inst  <= NOP_INST;
                        out_pc    <= pc;
                        out_fault <= 1'b1;
                        state     <= S_HOLD;
                    end else if (req_fire) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        out_inst  <= imem_resp_err ? NOP_INST : imem_resp_data;
                        out_pc    <= pc;
                        out_fault <= imem_resp_err;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        if (out_fault) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= pc + 32'd4;
                            state <= S_REQ;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) begin
                        state <= S_REQ;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Bench for the fetch unit: behavioural memory plus a transaction-level PC model.
// Every handshake is checked against the PC the model expects and the word memory holds there.
// Directed scenarios first, then a long randomized run with backpressure and redirects.
module tb_ysyx_23060096_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ysyx_23060096_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // memory behaviour knobs
    logic        g_rdy_rand   = 1'b0;
    logic        g_rdy_fixed  = 1'b0;
    int          g_lat_min    = 1;
    int          g_lat_max    = 1;
    logic [31:0] g_err_addr   = 32'h0000_0001;
    logic        g_err_region = 1'b0;

    // memory state
    logic        pend     = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt = 0;

    // architectural model
    logic [31:0] m_pc   = RST_PC;
    logic        m_halt = 1'b0;

    // previous-cycle observations
    logic        prev_stall    = 1'b0;
    logic        prev_redirect = 1'b0;
    logic [31:0] prev_inst, prev_pc;
    logic        prev_fault;

    logic [31:0] req_q[$];
    int          acc_cyc_q[$];
    logic [31:0] out_q[$];
    int          out_cyc_q[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic errf(input logic [31:0] a);
        return (a == g_err_addr) || (g_err_region && (a[11:8] == 4'hE));
    endfunction

    // One clock cycle: observe, check against the model, advance the model and the memory.
    task automatic step();
        logic        req_fire, out_fire, resp_fire, exp_fault;
        logic [31:0] exp_inst;
        #1;
        req_fire  = imem_req_valid && imem_req_ready;
        out_fire  = out_valid && out_ready;
        resp_fire = imem_resp_valid;
        if (!rst) begin
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_inst !== prev_inst || out_pc !== prev_pc || out_fault !== prev_fault) begin
                    n_fail++;
                    $display("FAIL hold_stable cyc=%0d: got v=%b inst=%h pc=%h f=%b, required v=1 inst=%h pc=%h f=%b",
                             cyc, out_valid, out_inst, out_pc, out_fault, prev_inst, prev_pc, prev_fault);
                end
            end
            if (prev_redirect) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_after_redirect cyc=%0d: got %b required 0", cyc, out_valid);
                end
            end
            if (imem_req_valid) begin
                n_checks++;
                if (imem_req_addr !== m_pc || m_halt) begin
                    n_fail++;
                    $display("FAIL req_addr cyc=%0d: got %h (halted=%b) required %h, not halted",
                             cyc, imem_req_addr, m_halt, m_pc);
                end
            end
            if (req_fire && pend) begin
                n_fail++;
                $display("FAIL one_outstanding cyc=%0d: got second request %h, required none", cyc, imem_req_addr);
            end
            if (out_fire) begin
                exp_fault = (m_pc[1:0] != 2'b00) || errf(m_pc);
                exp_inst  = exp_fault ? NOP : memf(m_pc);
                n_checks++;
                if (out_pc !== m_pc || out_inst !== exp_inst || out_fault !== exp_fault) begin
                    n_fail++;
                    $display("FAIL out_item cyc=%0d: got pc=%h inst=%h f=%b required pc=%h inst=%h f=%b",
                             cyc, out_pc, out_inst, out_fault, m_pc, exp_inst, exp_fault);
                end
                out_q.push_back(out_pc);
                out_cyc_q.push_back(cyc);
            end
            if (req_fire) begin
                req_q.push_back(imem_req_addr);
                acc_cyc_q.push_back(cyc);
            end
            if (redirect_valid) begin
                m_pc   = redirect_pc;
                m_halt = 1'b0;
            end else if (out_fire) begin
                if (out_fault) m_halt = 1'b1;
                else m_pc = m_pc + 32'd4;
            end
        end
        prev_stall    = !rst && out_valid && !out_ready && !redirect_valid;
        prev_redirect = !rst && redirect_valid;
        prev_inst     = out_inst;
        prev_pc       = out_pc;
        prev_fault    = out_fault;
        @(posedge clk);
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (resp_fire) pend = 1'b0;
            if (req_fire) begin
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                pend_cnt  = int'($urandom_range(g_lat_max, g_lat_min));
            end
        end
        @(negedge clk);
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        imem_resp_err   = 1'($urandom_range(0, 1));
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memf(pend_addr);
                imem_resp_err   = errf(pend_addr);
            end
        end
        imem_req_ready = g_rdy_rand ? ($urandom_range(0, 9) < 7) : g_rdy_fixed;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin step(); n++; end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_out_timeout: out_valid=%b required 1", name, out_valid);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 50) begin step(); n++; end
        n_checks++;
        if (imem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_req_timeout: imem_req_valid=%b required 1", name, imem_req_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        imem_resp_err = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        g_rdy_fixed = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step();
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_inst !== 32'd0 || out_fault !== 1'b0 || out_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_hold: got req=%b v=%b inst=%h f=%b pc=%h required 0 0 0 0 %h",
                     imem_req_valid, out_valid, out_inst, out_fault, out_pc, RST_PC);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || out_valid !== 1'b0 || out_inst !== 32'd0 || out_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_release: got req=%b addr=%h v=%b inst=%h pc=%h required 1 %h 0 0 %h",
                     imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, RST_PC, RST_PC);
        end
        m_pc = RST_PC; m_halt = 1'b0;
    endtask

    task automatic test_sequential();
        int n = 0;
        req_q.delete(); acc_cyc_q.delete(); out_q.delete(); out_cyc_q.delete();
        g_rdy_fixed = 1'b1; g_lat_min = 1; g_lat_max = 1;
        imem_req_ready = 1'b1; out_ready = 1'b1;
        step();
        while (out_q.size() < 3 && n < 60) begin step(); n++; end
        n_checks++;
        if (out_q.size() < 3 || req_q.size() < 3) begin
            n_fail++;
            $display("FAIL seq_count: got %0d outputs %0d requests required 3", out_q.size(), req_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (req_q[i] !== RST_PC + 32'(4 * i) || out_q[i] !== RST_PC + 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL seq_order[%0d]: got req=%h out=%h required %h", i, req_q[i], out_q[i], RST_PC + 32'(4 * i));
                end
            end
            n_checks++;
            if (out_cyc_q[0] - acc_cyc_q[0] != 2) begin
                n_fail++;
                $display("FAIL seq_latency: got %0d cycles required 2", out_cyc_q[0] - acc_cyc_q[0]);
            end
            n_checks++;
            if (out_cyc_q[1] - out_cyc_q[0] != 3 || out_cyc_q[2] - out_cyc_q[1] != 3) begin
                n_fail++;
                $display("FAIL seq_spacing: got %0d,%0d required 3,3", out_cyc_q[1] - out_cyc_q[0], out_cyc_q[2] - out_cyc_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] cap_inst, cap_pc;
        out_ready = 1'b0; g_rdy_fixed = 1'b1;
        wait_out("bp");
        cap_inst = out_inst; cap_pc = out_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_inst !== cap_inst || out_pc !== cap_pc || imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got v=%b inst=%h pc=%h req=%b required 1 %h %h 0",
                         i, out_valid, out_inst, out_pc, imem_req_valid, cap_inst, cap_pc);
            end
        end
        g_rdy_fixed = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wait_req("bp");
        n_checks++;
        if (imem_req_addr !== cap_pc + 32'd4) begin
            n_fail++;
            $display("FAIL bp_next_addr: got %h required %h", imem_req_addr, cap_pc + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        int n0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0010;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL rw_req_redirect: got req=%b addr=%h required 1 80000010", imem_req_valid, imem_req_addr);
        end
        g_lat_min = 3; g_lat_max = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        n0 = out_q.size();
        step();
        redirect_valid = 1'b0;
        g_lat_min = 1; g_lat_max = 1; g_rdy_fixed = 1'b1;
        wait_req("rw");
        n_checks++;
        if (imem_req_addr !== 32'h8000_0100 || out_q.size() != n0) begin
            n_fail++;
            $display("FAIL rw_drop: got addr=%h outputs=%0d required 80000100 and %0d", imem_req_addr, out_q.size(), n0);
        end
    endtask

    task automatic test_redirect_hold();
        int n0;
        out_ready = 1'b0; g_rdy_fixed = 1'b1;
        wait_out("rh");
        n0 = out_q.size();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; g_rdy_fixed = 1'b0;
        step();
        redirect_valid = 1'b0; out_ready = 1'b0;
        wait_req("rh");
        n_checks++;
        if (out_q.size() != n0 + 1 || imem_req_addr !== 32'h8000_0200) begin
            n_fail++;
            $display("FAIL rh_consume: got outputs=%0d addr=%h required %0d 80000200", out_q.size() - n0, imem_req_addr, 1);
        end
    endtask

    task automatic test_misaligned();
        int nreq;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        step();
        redirect_valid = 1'b0; g_rdy_fixed = 1'b1; out_ready = 1'b0;
        nreq = req_q.size();
        wait_out("mis");
        n_checks++;
        if (req_q.size() != nreq || out_fault !== 1'b1 || out_inst !== NOP || out_pc !== 32'h8000_0002) begin
            n_fail++;
            $display("FAIL mis_item: got reqs=%0d f=%b inst=%h pc=%h required 0 1 %h 80000002",
                     req_q.size() - nreq, out_fault, out_inst, out_pc, NOP);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mis_halt[%0d]: got v=%b req=%b required 0 0", i, out_valid, imem_req_valid);
            end
        end
        g_rdy_fixed = 1'b0;
        redirect_valid = 1'b1; redirect_pc = RST_PC;
        step();
        redirect_valid = 1'b0;
        wait_req("mis");
        n_checks++;
        if (imem_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL mis_resume: got %h required %h", imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_err_wrap();
        g_err_addr = RST_PC; g_rdy_fixed = 1'b1; out_ready = 1'b0;
        wait_out("err");
        n_checks++;
        if (out_fault !== 1'b1 || out_inst !== NOP || out_pc !== RST_PC) begin
            n_fail++;
            $display("FAIL err_item: got f=%b inst=%h pc=%h required 1 %h %h", out_fault, out_inst, out_pc, NOP, RST_PC);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL err_halt[%0d]: got v=%b req=%b required 0 0", i, out_valid, imem_req_valid);
            end
        end
        g_err_addr = 32'h0000_0001;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_out("wrap");
        n_checks++;
        if (out_pc !== 32'hFFFF_FFFC || out_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_item: got pc=%h f=%b required fffffffc 0", out_pc, out_fault);
        end
        g_rdy_fixed = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        wait_req("wrap");
        n_checks++;
        if (imem_req_addr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h required 00000000", imem_req_addr);
        end
    endtask

    task automatic test_random();
        int n0, r;
        g_rdy_rand = 1'b1; g_lat_min = 1; g_lat_max = 4; g_err_region = 1'b1;
        n0 = out_q.size();
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 99) < 5);
            r = int'($urandom_range(0, 9));
            if (r < 8)       redirect_pc = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            else if (r == 8) redirect_pc = (32'h8000_0000 + $urandom_range(0, 4095)) | 32'h1;
            else             redirect_pc = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
            step();
        end
        redirect_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (out_q.size() - n0 <= 100) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d deliveries required more than 100", out_q.size() - n0);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_misaligned();
        test_err_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_ifu.md
# ysyx_23060096_ifu

Instruction fetch unit for the NPC core. It owns the architectural PC and issues one instruction-memory read at a time through a valid/ready request channel. It buffers the returned word and hands `{inst, pc}` to the decode/execute stage through a valid/ready output channel. It also accepts PC redirects (branches, jumps) from execute.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC value loaded on reset.
- `NOP_INST`, default `32'h0000_0013`: word driven on `out_inst` for faulting fetches.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, input, 1: sole clock, rising edge.
  - `rst`, input, 1: synchronous reset, active-high.
- Instruction memory request channel:
  - `imem_req_valid`, output, 1: fetch request valid.
  - `imem_req_ready`, input, 1: memory accepts the request this cycle.
  - `imem_req_addr`, output, 32: fetch address. It always equals the PC register.
- Instruction memory response channel:
  - `imem_resp_valid`, input, 1: response word valid. There is no backpressure on this channel.
  - `imem_resp_data`, input, 32: instruction word.
  - `imem_resp_err`, input, 1: access error for this response.
- Output channel to decode:
  - `out_valid`, output, 1: buffered instruction valid.
  - `out_ready`, input, 1: downstream consumes it this cycle.
  - `out_inst`, output, 32: instruction.
  - `out_pc`, output, 32: PC of `out_inst`.
  - `out_fault`, output, 1: fetch fault (misaligned PC or access error).
- Redirect from execute:
  - `redirect_valid`, input, 1: replace the PC with `redirect_pc`.
  - `redirect_pc`, input, 32: redirect target.

## Operation
- States:
  - REQ: requesting.
  - WAIT: awaiting the response.
  - HOLD: output buffered.
  - DROP: discarding a stale response.
  - HALT: stopped after a fault.
- Memory contract:
  - At most one request is outstanding.
  - Exactly one response returns per accepted request.
  - The response arrives no earlier than the cycle after acceptance.
  - `imem_req_addr` may change while `imem_req_valid` is high and the request is unaccepted.
- REQ behaviour:
  - If `pc[1:0]==0`, assert `imem_req_valid`. On `imem_req_ready`, go to WAIT.
  - If `pc[1:0]!=0`, do not request. Load the buffer with `{NOP_INST, pc, fault=1}` and go to HOLD.
- WAIT behaviour:
  - On `imem_resp_valid`, load the buffer with `{resp_err ? NOP_INST : resp_data, pc, resp_err}` and go to HOLD.
- HOLD behaviour:
  - `out_valid=1`, and the buffer is held stable until the handshake `out_valid & out_ready`.
  - On handshake with fault=0: `pc <= pc + 4` (mod 2^32, wraps `32'hFFFF_FFFC` to `0`), go to REQ.
  - On handshake with fault=1: go to HALT with the PC unchanged.
- DROP behaviour:
  - On `imem_resp_valid`, discard the response and go to REQ.
- HALT behaviour:
  - No requests are issued and `out_valid=0`.
  - Leave only on redirect.
- Redirect (`redirect_valid`) has priority over every other PC update. It always sets `pc <= redirect_pc`. Next state depends on the current state:
  - REQ, request accepted the same cycle: go to DROP.
  - REQ, request not accepted: stay in REQ. The new address is presented next cycle.
  - WAIT, no response this cycle: go to DROP.
  - WAIT, response the same cycle: discard the response and go to REQ.
  - DROP, response the same cycle: discard it and go to REQ.
  - DROP, no response: stay in DROP.
  - HOLD: discard the buffer (`out_valid=0` next cycle) and go to REQ. A same-cycle handshake still counts as consumed, but the redirect PC wins over `pc+4`.
  - HALT: go to REQ.
- `imem_resp_valid` in REQ, HOLD or HALT is a protocol violation and is ignored.

## Timing
- Reset values while `rst` is high and in the first cycle after it:
  - `pc=RESET_PC`, state=REQ.
  - `out_valid=0`, `out_inst=0`, `out_fault=0`, `out_pc=RESET_PC`.
  - `imem_req_valid` is forced to 0 while `rst` is high.
- Reset mid-operation: all state is abandoned. A response that arrives later is ignored because the state is REQ.
- Request launch: `imem_req_valid` is combinational from state and `pc`. It is high in the first cycle after `rst` falls.
- Latency, with the request accepted in cycle t:
  - Response at t+1 gives `out_valid` at t+2.
  - A handshake in cycle h gives the next `imem_req_valid` at h+1.
  - Best throughput is one instruction per 3 cycles.
- `out_inst`, `out_pc` and `out_fault` are registered, with no combinational path from the imem inputs.
- `out_valid` never drops without a handshake or a redirect.

## Test plan
- **Reset and sequential fetch.** Stimulus: `RESET_PC=0x8000_0000`, memory with 1-cycle latency and always ready, `out_ready=1`. Required: requests to `0x80000000`, `0x80000004`, `0x80000008`, and `out_pc` values in that order with matching `out_inst`. Consecutive `out_valid` pulses are 3 cycles apart.
- **Backpressure.** Stimulus: hold `out_ready=0` for 5 cycles while `out_valid=1`. Required: `out_inst` and `out_pc` are stable and no new request is issued. `out_ready=1` → the next request is at `pc+4`.
- **Redirect during WAIT.** Stimulus: request to `0x80000010` accepted, `redirect_pc=0x80000100` the next cycle, response 3 cycles later. Required: the stale word never appears on `out_*`, and the next request is to `0x80000100`.
- **Redirect coincident with handshake in HOLD.** Stimulus: redirect to `0x80000200` in the same cycle as the handshake. Required: the instruction is consumed once, and the next request is to `0x80000200`, not `pc+4`.
- **Misaligned redirect.** Stimulus: redirect to `0x80000002`. Required: no imem request; `out_valid=1`, `out_fault=1`, `out_inst=0x00000013`, `out_pc=0x80000002`. After the handshake the unit is in HALT. A later redirect to `0x80000000` resumes fetching.
- **Access error and wrap.** Stimulus: `imem_resp_err=1`. Required: `out_fault=1`, `out_inst=NOP_INST`, then HALT. Stimulus: redirect to `0xFFFFFFFC` with a good response and handshake. Required: the next request is to `0x00000000`.
